// File: rtl/matrix_mopa_unit.sv
// Outer-product-accumulate engine for the 4x4 int8 matrix tile: snapshots the
// tile, folds in +/- a*b^T one row per cycle, then issues one bulk write.
module matrix_mopa_unit (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    input  logic             sub,
    input  logic             sat,
    input  logic [3:0][31:0] m_in,
    output logic             busy,
    output logic             done,
    output logic             mopa_en,
    output logic [3:0][31:0] mopa_data,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Handshake: start is a request sampled only in IDLE; mopa_en/done form a
    // single-cycle strobe with mopa_data valid in that same cycle.
    state_t           state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic             sub_q, sub_d;
    logic             sat_q, sat_d;
    logic [3:0][31:0] m_q, m_d;
    logic [3:0][31:0] res_q, res_d;
    logic [31:0]      row_val;

    function automatic logic [7:0] lane_op(input logic [7:0] e,
                                           input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic       do_sub,
                                           input logic       do_sat);
        logic signed [15:0] p;
        logic        [16:0] s;
        logic        [7:0]  r;
        p = $signed(a) * $signed(b);
        s = {{9{e[7]}}, e};
        s = do_sub ? (s - {p[15], p}) : (s + {p[15], p});
        r = s[7:0];
        // Bits above the int8 range disagree with the sign bit => out of range.
        if (do_sat) begin
            if (!s[16] && (s[15:7] != 9'h000)) begin
                r = 8'h7F;
            end else if (s[16] && (s[15:7] != 9'h1FF)) begin
                r = 8'h80;
            end
        end
        return r;
    endfunction

    always_comb begin
        row_val = '0;
        for (int j = 0; j < 4; j++) begin
            row_val[8*j +: 8] = lane_op(m_q[row_q][8*j +: 8],
                                        a_q[{row_q, 3'b000} +: 8],
                                        b_q[8*j +: 8],
                                        sub_q, sat_q);
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        sat_d   = sat_q;
        m_d     = m_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    sub_d   = sub;
                    sat_d   = sat;
                    m_d     = m_in;
                    row_d   = 2'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                res_d[row_q] = row_val;
                row_d        = row_q + 2'd1;
                if (row_q == 2'd3) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            row_q   <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            sat_q   <= 1'b0;
            m_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            sat_q   <= sat_d;
            m_q     <= m_d;
            res_q   <= res_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign mopa_en     = (state_q == WRITE);
    assign done        = (state_q == WRITE);
    assign mopa_data   = res_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_matrix_mopa_unit.sv
// Randomized and directed bench for matrix_mopa_unit with a queue-based
// scoreboard and an arithmetic reference model of the outer-product update.
module tb_matrix_mopa_unit;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic             sub;
    logic             sat;
    logic [3:0][31:0] m_in;
    logic             busy;
    logic             done;
    logic             mopa_en;
    logic [3:0][31:0] mopa_data;
    logic [1:0]       dbg_state;

    logic [127:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;

    always #5 clk = ~clk;

    matrix_mopa_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .sub        (sub),
        .sat        (sat),
        .m_in       (m_in),
        .busy       (busy),
        .done       (done),
        .mopa_en    (mopa_en),
        .mopa_data  (mopa_data),
        .dbg_state_o(dbg_state)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Reference: each lane is an int8 plus/minus an int8*int8 product, in plain integers.
    function automatic logic [127:0] model(input logic [31:0] a, input logic [31:0] b,
                                           input logic s_sub, input logic s_sat,
                                           input logic [127:0] m);
        logic [127:0] res;
        byte ai, bj, e;
        int  s;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                ai = a[8*r +: 8];
                bj = b[8*j +: 8];
                e  = m[32*r + 8*j +: 8];
                s  = s_sub ? (int'(e) - int'(ai) * int'(bj)) : (int'(e) + int'(ai) * int'(bj));
                if (s_sat) begin
                    if (s > 127)  s = 127;
                    if (s < -128) s = -128;
                end
                res[32*r + 8*j +: 8] = s[7:0];
            end
        end
        return res;
    endfunction

    // Monitor: every write-back strobe consumes one expected result.
    always @(negedge clk) begin
        logic [127:0] e;
        if (mopa_en || done) check("done_eq_mopa_en", done, mopa_en);
        if (mopa_en) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_mopa_en: got data %h required no write", mopa_data);
            end else begin
                e = exp_q.pop_front();
                check("mopa_data", mopa_data, e);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge of cycle T+6.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s_sub,
                          input logic s_sat, input logic [127:0] m, input logic [127:0] exp);
        op_a  = a;
        op_b  = b;
        sub   = s_sub;
        sat   = s_sat;
        m_in  = m;
        start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("busy_during_op", busy, 1'b1);
            check("mopa_en_timing", mopa_en, (k == 5) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        check("busy_after_op", busy, 1'b0);
    endtask

    initial begin
        logic [127:0] m;
        logic [31:0]  a, b;
        logic         s0, s1;
        int           p0;

        rst = 1'b0; start = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; sat = 1'b0; m_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_mopa_en", mopa_en, 1'b0);
        check("reset_mopa_data", mopa_data, '0);
        @(negedge clk);
        rst = 1'b1;

        // Wrap accumulate from a zero tile.
        run_op(32'h04030201, 32'h01010101, 1'b0, 1'b0, '0,
               {32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101});

        // Signed product: (-1)*2 added to 5; untouched rows pass through.
        m = {32'h99AABBCC, 32'h55667788, 32'h11223344, 32'h00000005};
        for (int st = 0; st < 2; st++) begin
            run_op(32'h000000FF, 32'h00000002, 1'b0, st[0], m,
                   {32'h99AABBCC, 32'h55667788, 32'h11223344, 32'h00000003});
        end

        // Overflow and underflow, wrap versus saturate.
        run_op(32'h1, 32'h1, 1'b0, 1'b0, {96'h0, 32'h7F}, {96'h0, 32'h80});
        run_op(32'h1, 32'h1, 1'b0, 1'b1, {96'h0, 32'h7F}, {96'h0, 32'h7F});
        run_op(32'h1, 32'h1, 1'b1, 1'b0, {96'h0, 32'h80}, {96'h0, 32'h7F});
        run_op(32'h1, 32'h1, 1'b1, 1'b1, {96'h0, 32'h80}, {96'h0, 32'h80});

        // Start while busy is ignored and m_in is snapshotted at accept time.
        p0 = n_pulses;
        m  = {32'h01020304, 32'h7F7F7F7F, 32'h80808080, 32'h00000010};
        op_a = 32'h81FF7F02; op_b = 32'h02FE7F80; sub = 1'b0; sat = 1'b1; m_in = m;
        exp_q.push_back(model(32'h81FF7F02, 32'h02FE7F80, 1'b0, 1'b1, m));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1; op_a = 32'h11111111; op_b = 32'h22222222; sub = 1'b1; m_in = '1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        check("snapshot_single_pulse", n_pulses - p0, 1);
        check("snapshot_idle_after", busy, 1'b0);

        // Reset mid-operation aborts; reset also beats a coincident start.
        p0 = n_pulses;
        op_a = 32'h01010101; op_b = 32'h01010101; sub = 1'b0; sat = 1'b0; m_in = '0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        check("midop_reset_busy", busy, 1'b0);
        check("midop_reset_data", mopa_data, '0);
        check("midop_reset_en", mopa_en, 1'b0);
        @(posedge clk);
        #1;
        check("reset_beats_start", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("post_reset_idle", busy, 1'b0);
        end
        check("no_pulse_after_reset", n_pulses - p0, 0);
        m = {$urandom, $urandom, $urandom, $urandom};
        a = $urandom; b = $urandom;
        run_op(a, b, 1'b0, 1'b1, m, model(a, b, 1'b0, 1'b1, m));

        // Randomized back-to-back operations.
        for (int i = 0; i < 40; i++) begin
            m  = {$urandom, $urandom, $urandom, $urandom};
            a  = $urandom;
            b  = $urandom;
            s0 = 1'($urandom_range(0, 1));
            s1 = 1'($urandom_range(0, 1));
            run_op(a, b, s0, s1, m, model(a, b, s0, s1, m));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
